signal_expansioner: RTL and testbench
=====================================

Name: signal_expansioner

Overview:
- Pulse stretcher: SIG_OUT follows SIG_IN and is held high for EXTEND_LEN extra clock cycles after SIG_IN falls.
- Used by the data-frame generator to widen the trigger window, covering pre-acquisition and post-trigger samples.
- Single clock domain, fully registered output.

Parameters:
- MAX_EXTEND_LEN_WIDTH, 5, bit width of EXTEND_LEN and of the internal hold counter. Legal range 1..16.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset asserted).
- EXTEND_LEN  input  MAX_EXTEND_LEN_WIDTH  number of cycles SIG_OUT stays high after SIG_IN deasserts. Unsigned.
- SIG_IN  input  1  level/pulse to be stretched.
- SIG_OUT  output  1  stretched signal, registered.

Behaviour:
- State: hold counter cnt (MAX_EXTEND_LEN_WIDTH bits, unsigned) and output register out_q. SIG_OUT = out_q.
- Reset (RESET==0 at a rising edge): cnt <= 0, out_q <= 0. This takes priority over SIG_IN. SIG_OUT reads 0 from the cycle after the reset edge until the release.
- Normal operation at each rising edge, in priority order:
  1. SIG_IN==1: cnt <= EXTEND_LEN, out_q <= 1. A re-trigger always reloads the counter, so holds never accumulate.
  2. SIG_IN==0 and cnt!=0: cnt <= cnt-1, out_q <= 1.
  3. SIG_IN==0 and cnt==0: out_q <= 0, cnt stays 0.
- Latency: SIG_OUT rises 1 cycle after SIG_IN is sampled high.
- Pulse width: a SIG_IN pulse of N cycles gives SIG_OUT high for exactly N+EXTEND_LEN cycles, starting 1 cycle late.
- EXTEND_LEN==0: SIG_OUT is SIG_IN delayed by one register.
- EXTEND_LEN is sampled only on cycles where SIG_IN==1. Changing it during the hold does not affect the hold in progress.
- Two SIG_IN pulses separated by a gap of G cycles, with G <= EXTEND_LEN: SIG_OUT stays continuously high (merged window).
- Gap G > EXTEND_LEN: SIG_OUT drops for exactly G-EXTEND_LEN cycles.
- Maximum EXTEND_LEN (all ones): counter never wraps. It decrements to 0 and stops there; no underflow.
- Reset asserted mid-hold: counter and output clear at that edge. After release, nothing is output until SIG_IN rises again.
- No combinational path from any input to SIG_OUT.

Decomposition:
- Shared package: default MAX_EXTEND_LEN_WIDTH constant, shared with the frame-generator PRE_ACQUIASION_LEN width (MAX_DELAY_CNT_WIDTH).
- No typedefs needed. No sub-modules; a single flat module (counter plus output register) is natural.

Test Plan:
- Reset check: hold RESET=0 for 3 cycles while SIG_IN=1 -> SIG_OUT=0 throughout. After release with SIG_IN=0 -> SIG_OUT stays 0.
- Single pulse: EXTEND_LEN=4, SIG_IN high 1 cycle at edge t -> SIG_OUT high at edges t..t+4 (5 cycles), low from t+5.
- Zero extension: EXTEND_LEN=0, SIG_IN high 3 cycles -> SIG_OUT high exactly 3 cycles, delayed by 1.
- Merge/split: EXTEND_LEN=3. Pulses separated by a 2-cycle gap -> SIG_OUT continuous. Separated by a 6-cycle gap -> SIG_OUT low for exactly 3 cycles.
- Max length: EXTEND_LEN=31 (width 5), 1-cycle pulse -> SIG_OUT high 32 cycles, then 0, with no wrap-around re-assertion.
- Mid-hold reset: EXTEND_LEN=10, pulse, then RESET=0 for one cycle 3 cycles later -> SIG_OUT 0 from the next cycle and stays 0 with SIG_IN=0.

Source files
------------

// File: rtl/signal_expansioner_pkg.sv
// Shared widths for the data-frame generator and its trigger-window stretcher.
// The stretcher hold width follows the pre-acquisition delay counter width.
package signal_expansioner_pkg;

  localparam int MAX_DELAY_CNT_WIDTH       = 5;
  localparam int DEFAULT_EXTEND_LEN_WIDTH  = MAX_DELAY_CNT_WIDTH;

endpackage

// File: rtl/signal_expansioner.sv
// Pulse stretcher: SIG_OUT follows SIG_IN and stays high for EXTEND_LEN extra
// cycles after SIG_IN falls. Output is registered; no input-to-output comb path.
module signal_expansioner
  import signal_expansioner_pkg::*;
#(
  parameter int MAX_EXTEND_LEN_WIDTH = DEFAULT_EXTEND_LEN_WIDTH
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
  input  logic                            SIG_IN,
  output logic                            SIG_OUT
);

  localparam logic [MAX_EXTEND_LEN_WIDTH-1:0] CNT_ONE  = MAX_EXTEND_LEN_WIDTH'(1);
  localparam logic [MAX_EXTEND_LEN_WIDTH-1:0] CNT_ZERO = '0;

  logic [MAX_EXTEND_LEN_WIDTH-1:0] cnt;
  logic                            out_q;

  // A trigger always reloads the hold, so back-to-back pulses never accumulate;
  // the counter stops at zero instead of wrapping.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt   <= CNT_ZERO;
      out_q <= 1'b0;
    end else if (SIG_IN) begin
      cnt   <= EXTEND_LEN;
      out_q <= 1'b1;
    end else if (cnt != CNT_ZERO) begin
      cnt   <= cnt - CNT_ONE;
      out_q <= 1'b1;
    end else begin
      cnt   <= CNT_ZERO;
      out_q <= 1'b0;
    end
  end

  assign SIG_OUT = out_q;

endmodule

// File: tb/tb_signal_expansioner.sv
// Directed bench for signal_expansioner: a cycle-age reference model is checked
// every cycle, plus hand-computed pulse widths, latencies and gap lengths.
module tb_signal_expansioner;

  localparam int W = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] EXTEND_LEN;
  logic         SIG_IN;
  logic         SIG_OUT;

  int checks = 0;
  int errors = 0;

  signal_expansioner #(.MAX_EXTEND_LEN_WIDTH(W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EXTEND_LEN (EXTEND_LEN),
    .SIG_IN     (SIG_IN),
    .SIG_OUT    (SIG_OUT)
  );

  always #5 CLK = ~CLK;

  // Reference: output is high while the age (cycles since the last sampled
  // high SIG_IN) is within the extension captured with that high sample.
  bit m_valid = 1'b0;
  int m_age   = 0;
  int m_ext   = 0;
  bit m_exp;

  always @(posedge CLK) begin
    if (!RESET) begin
      m_valid <= 1'b0;
    end else if (SIG_IN) begin
      m_valid <= 1'b1;
      m_age   <= 0;
      m_ext   <= int'(EXTEND_LEN);
    end else if (m_age < 1000000) begin
      m_age   <= m_age + 1;
    end
  end

  assign m_exp = m_valid && (m_age <= m_ext);

  // Advance one cycle and compare the DUT against the model away from the edge.
  task automatic tick();
    @(negedge CLK);
    checks++;
    if (SIG_OUT !== m_exp) begin
      errors++;
      $display("FAIL model t=%0t SIG_OUT=%b expected=%b", $time, SIG_OUT, m_exp);
    end
  endtask

  task automatic expect_int(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Drive SIG_IN from pat (bit i in cycle i) for n cycles; measure the output.
  task automatic run_pattern(input logic [63:0] pat, input int n,
                             output int highs, output int rises, output int gap1);
    logic prev;
    int   lows_after_first;
    prev = 1'b0;
    highs = 0; rises = 0; gap1 = -1; lows_after_first = 0;
    for (int i = 0; i < n; i++) begin
      SIG_IN = pat[i];
      tick();
      if (SIG_OUT === 1'b1) begin
        highs++;
        if (!prev) begin
          rises++;
          if (rises == 2) gap1 = lows_after_first;
        end
      end else if (rises >= 1) begin
        lows_after_first++;
      end
      prev = (SIG_OUT === 1'b1);
    end
    SIG_IN = 1'b0;
  endtask

  int h, r, g;

  initial begin
    RESET      = 1'b0;
    SIG_IN     = 1'b1;
    EXTEND_LEN = W'(4);

    // Reset held with SIG_IN high: output must stay low.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_int("reset_out_low", int'(SIG_OUT), 0);
    end
    RESET  = 1'b1;
    SIG_IN = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    expect_int("post_reset_idle", int'(SIG_OUT), 0);

    // Single 1-cycle pulse, EXTEND_LEN=4: one cycle latency, 5 cycles high.
    EXTEND_LEN = W'(4);
    SIG_IN = 1'b1;
    tick();
    expect_int("latency_first_high", int'(SIG_OUT), 1);
    SIG_IN = 1'b0;
    h = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (SIG_OUT === 1'b1) h++;
    end
    expect_int("single_pulse_width", h, 5);

    // Zero extension: 3-cycle pulse passes through delayed by one register.
    EXTEND_LEN = W'(0);
    run_pattern(64'b111, 8, h, r, g);
    expect_int("zero_ext_width", h, 3);
    expect_int("zero_ext_rises", r, 1);

    // Merge: EXTEND_LEN=3, 2-cycle gap keeps the window continuous.
    EXTEND_LEN = W'(3);
    run_pattern(64'b1001, 14, h, r, g);
    expect_int("merge_width", h, 7);
    expect_int("merge_rises", r, 1);

    // Split: 6-cycle gap drops the output for 6-3 = 3 cycles.
    run_pattern(64'h81, 16, h, r, g);
    expect_int("split_width", h, 8);
    expect_int("split_rises", r, 2);
    expect_int("split_gap", g, 3);

    // Maximum extension: 32 cycles high, no wrap-around re-assertion.
    EXTEND_LEN = W'(31);
    run_pattern(64'b1, 60, h, r, g);
    expect_int("max_ext_width", h, 32);
    expect_int("max_ext_rises", r, 1);

    // Changing EXTEND_LEN mid-hold leaves the running hold untouched.
    EXTEND_LEN = W'(5);
    SIG_IN = 1'b1;
    tick();
    SIG_IN = 1'b0;
    EXTEND_LEN = W'(1);
    h = (SIG_OUT === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (SIG_OUT === 1'b1) h++;
    end
    expect_int("ext_change_mid_hold", h, 6);

    // Mid-hold reset: EXTEND_LEN=10, reset three cycles after the pulse.
    EXTEND_LEN = W'(10);
    SIG_IN = 1'b1;
    tick();
    SIG_IN = 1'b0;
    tick();
    tick();
    expect_int("hold_before_reset", int'(SIG_OUT), 1);
    RESET = 1'b0;
    tick();
    expect_int("mid_hold_reset_clear", int'(SIG_OUT), 0);
    RESET = 1'b1;
    h = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (SIG_OUT === 1'b1) h++;
    end
    expect_int("after_reset_quiet", h, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
